sysid_checker_master: RTL and testbench



---
 rtl/sysid_checker_master.sv | 174 +++++++++++++++++
 tb/tb_sysid_checker_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sysid_checker_master                                                     |
// | Avalon-MM read master: fetches the system-ID word (addr 0) and the       |
// | timestamp word (addr 1), compares both with build-time values and        |
// | reports pass / fail_code. Define SYSID_CHECK_TIMEOUT_EN to abort a read  |
// | stalled for TIMEOUT_CYCLES cycles.                                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sysid_checker_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h57FC_5188,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RD_ID = 3'd1;
    localparam logic [2:0] c_ST_RD_TS = 3'd2;
    localparam logic [2:0] c_ST_EVAL  = 3'd3;
    localparam logic [2:0] c_ST_FIN   = 3'd4;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
            $error("TIMEOUT_CYCLES must be within 1..65535");
        end
    endgenerate

    logic [2:0]  r_state, w_next_state;
    logic        r_avm_address, w_avm_address;
    logic        r_avm_read, w_avm_read;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_pass, w_pass;
    logic [1:0]  r_fail_code, w_fail_code;
    logic [31:0] r_id_value, w_id_value;
    logic [31:0] r_ts_value, w_ts_value;

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT = TIMEOUT_CYCLES[15:0];
    logic [15:0] r_wait_cnt, w_wait_cnt;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_avm_address <= 1'b0;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail_code   <= 2'b00;
            r_id_value    <= 32'h0;
            r_ts_value    <= 32'h0;
`ifdef SYSID_CHECK_TIMEOUT_EN
            r_wait_cnt    <= 16'h0;
`endif
        end else begin
            r_state       <= w_next_state;
            r_avm_address <= w_avm_address;
            r_avm_read    <= w_avm_read;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_pass        <= w_pass;
            r_fail_code   <= w_fail_code;
            r_id_value    <= w_id_value;
            r_ts_value    <= w_ts_value;
`ifdef SYSID_CHECK_TIMEOUT_EN
            r_wait_cnt    <= w_wait_cnt;
`endif
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_avm_address = r_avm_address;
        w_avm_read    = r_avm_read;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_pass        = r_pass;
        w_fail_code   = r_fail_code;
        w_id_value    = r_id_value;
        w_ts_value    = r_ts_value;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state  = c_ST_RD_ID;
                    w_avm_address = 1'b0;
                    w_avm_read    = 1'b1;
                    w_busy        = 1'b1;
                    w_pass        = 1'b0;
                    w_fail_code   = 2'b00;
                end
            end
            c_ST_RD_ID: begin
                // Keep read asserted into the timestamp read: no idle gap.
                if (!avm_waitrequest) begin
                    w_id_value    = avm_readdata;
                    w_avm_address = 1'b1;
                    w_next_state  = c_ST_RD_TS;
                end
            end
            c_ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    w_ts_value   = avm_readdata;
                    w_avm_read   = 1'b0;
                    w_next_state = c_ST_EVAL;
                end
            end
            c_ST_EVAL: begin
                if (r_id_value != EXPECTED_ID) begin
                    w_fail_code = 2'b01;
                end else if (r_ts_value != EXPECTED_TIMESTAMP) begin
                    w_fail_code = 2'b10;
                end else begin
                    w_pass = 1'b1;
                end
                w_done       = 1'b1;
                w_busy       = 1'b0;
                w_next_state = c_ST_FIN;
            end
            c_ST_FIN: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase

`ifdef SYSID_CHECK_TIMEOUT_EN
        w_wait_cnt = r_wait_cnt;
        if (w_next_state != r_state) begin
            w_wait_cnt = 16'h0;
        end else if ((r_state == c_ST_RD_ID || r_state == c_ST_RD_TS) && avm_waitrequest) begin
            w_wait_cnt = r_wait_cnt + 16'd1;
        end
        if ((r_state == c_ST_RD_ID || r_state == c_ST_RD_TS) && avm_waitrequest &&
            (r_wait_cnt + 16'd1 == c_TIMEOUT)) begin
            w_avm_read   = 1'b0;
            w_fail_code  = 2'b11;
            w_pass       = 1'b0;
            w_done       = 1'b1;
            w_busy       = 1'b0;
            w_wait_cnt   = 16'h0;
            w_next_state = c_ST_FIN;
        end
`endif
    end

    assign avm_address     = r_avm_address;
    assign avm_read        = r_avm_read;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign fail_code       = r_fail_code;
    assign id_value        = r_id_value;
    assign timestamp_value = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sysid_checker_master                                                  |
// | Directed bench: small Avalon slave model with programmable stalls.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sysid_checker_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [31:0] id_value;
    logic [31:0] timestamp_value;

    logic [31:0] id_resp  = 32'h0;
    logic [31:0] ts_resp  = 32'h57FC_5188;
    int          wait_n   = 0;
    logic        stall_ts = 1'b0;
    int          stall_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_edge = 0;
    int n_done   = 0;
    int n_rd     = 0;
    int stab_err = 0;
    int lat;
    logic prev_stall = 1'b0;
    logic prev_read  = 1'b0;
    logic prev_addr  = 1'b0;

    sysid_checker_master #(
        .EXPECTED_ID        (32'h0000_0000),
        .EXPECTED_TIMESTAMP (32'h57FC_5188),
        .TIMEOUT_CYCLES     (8)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_code       (fail_code),
        .id_value        (id_value),
        .timestamp_value (timestamp_value)
    );

    always #5 clock = ~clock;

    assign avm_readdata    = avm_address ? ts_resp : id_resp;
    assign avm_waitrequest = avm_read && ((avm_address && stall_ts) || (stall_cnt < wait_n));

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else                             stall_cnt <= 0;
        if (avm_read && !avm_waitrequest) n_rd <= n_rd + 1;
    end

    // Address and read must not move while the slave is stalling.
    always @(negedge clock) begin
        if (done) n_done = n_done + 1;
        if (!reset && prev_stall && (avm_read !== prev_read || avm_address !== prev_addr))
            stab_err = stab_err + 1;
        prev_stall = avm_read && avm_waitrequest;
        prev_read  = avm_read;
        prev_addr  = avm_address;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        start_edge = cyc;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done) begin
                l = cyc - start_edge;
                break;
            end
        end
    endtask

    task automatic clear_counts();
        @(negedge clock);
        n_done = 0;
        n_rd   = 0;
        stab_err = 0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail", 32'(fail_code), 32'd0);
        check("rst_id", id_value, 32'h0);
        check("rst_ts", timestamp_value, 32'h0);

        // Zero-wait, matching words: cycle-exact read sequence.
        clear_counts();
        pulse_start();
        check("t1_read0", 32'(avm_read), 32'd1);
        check("t1_addr0", 32'(avm_address), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check("t1_read1", 32'(avm_read), 32'd1);
        check("t1_addr1", 32'(avm_address), 32'd1);
        @(negedge clock);
        check("t1_eval_read", 32'(avm_read), 32'd0);
        check("t1_eval_done", 32'(done), 32'd0);
        @(negedge clock);
        check("t1_done", 32'(done), 32'd1);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_fail", 32'(fail_code), 32'd0);
        check("t1_ts", timestamp_value, 32'h57FC_5188);
        check("t1_busy_fin", 32'(busy), 32'd0);
        @(negedge clock);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_nrd", 32'(n_rd), 32'd2);

        // ID mismatch.
        id_resp = 32'h0000_0001;
        clear_counts();
        pulse_start();
        wait_done(lat);
        check("t2_lat", 32'(lat), 32'd3);
        repeat (5) @(negedge clock);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_fail", 32'(fail_code), 32'd1);
        check("t2_id", id_value, 32'h0000_0001);
        check("t2_ndone", 32'(n_done), 32'd1);

        // Timestamp mismatch with 3 stall cycles on each read.
        id_resp = 32'h0;
        ts_resp = 32'h57FC_5189;
        wait_n  = 3;
        clear_counts();
        pulse_start();
        wait_done(lat);
        check("t3_lat", 32'(lat), 32'd9);
        check("t3_fail", 32'(fail_code), 32'd2);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_stable", 32'(stab_err), 32'd0);
        check("t3_nrd", 32'(n_rd), 32'd2);

        // Reset while the timestamp read is stalled.
        ts_resp  = 32'h57FC_5188;
        wait_n   = 0;
        stall_ts = 1'b1;
        clear_counts();
        pulse_start();
        repeat (3) @(negedge clock);
        check("t4_stalled_read", 32'(avm_read), 32'd1);
        check("t4_stalled_addr", 32'(avm_address), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_async_read", 32'(avm_read), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_pass", 32'(pass), 32'd0);
        check("t4_fail", 32'(fail_code), 32'd0);
        check("t4_ts", timestamp_value, 32'h0);
        @(negedge clock) reset = 1'b0;
        stall_ts = 1'b0;
        pulse_start();
        wait_done(lat);
        check("t4_lat", 32'(lat), 32'd3);
        check("t4_repass", 32'(pass), 32'd1);

        // Second start while busy is ignored.
        wait_n = 3;
        clear_counts();
        pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        wait_done(lat);
        repeat (12) @(negedge clock);
        check("t5_ndone", 32'(n_done), 32'd1);
        check("t5_nrd", 32'(n_rd), 32'd2);
        check("t5_busy", 32'(busy), 32'd0);

        // start held high for 7 edges: accepted at edge 0 and edge 5.
        wait_n = 0;
        clear_counts();
        @(negedge clock) start = 1'b1;
        repeat (7) @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        check("t6_ndone", 32'(n_done), 32'd2);
        check("t6_nrd", 32'(n_rd), 32'd4);

        // Timestamp read stalled indefinitely.
        stall_ts = 1'b1;
        clear_counts();
        pulse_start();
        repeat (20) @(negedge clock);
`ifdef SYSID_CHECK_TIMEOUT_EN
        check("t7_fail", 32'(fail_code), 32'd3);
        check("t7_read", 32'(avm_read), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_ndone", 32'(n_done), 32'd1);
`else
        check("t7_busy", 32'(busy), 32'd1);
        check("t7_read", 32'(avm_read), 32'd1);
        check("t7_ndone", 32'(n_done), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        stall_ts = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
